sample_stream_reader: RTL and testbench
=======================================

SAMPLE_STREAM_READER -- requirements
Module: sample_stream_reader

Interface
REQ-001 Parameter NUM_SAMPLES, 4096, number of captured sample indices streamed per frame (address width 12).
REQ-002 Parameter RD_LATENCY, 2, clk cycles from a Read_Address change to valid RAM q data.
REQ-003 Parameter HEADER_BYTE, 8'hA5, first byte of every frame.
REQ-004 clk  in  1  single block clock (VGA_CLK domain).
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 Writing_Finish_Flag  in  1  capture-complete level from the CS_I-domain sample writer; asynchronous to clk.
REQ-007 Read_Address  out  12  read address into the six load-sample RAMs, Nios port.
REQ-008 PhaseA_Voltage_In, PhaseB_Voltage_In, PhaseC_Voltage_In  in  8 each  RAM q for load voltages.
REQ-009 PhaseA_Current_In, PhaseB_Current_In, PhaseC_Current_In  in  8 each  RAM q for load currents.
REQ-010 Stream_Data  out  8  byte to the downstream consumer (UART/Nios FIFO).
REQ-011 Stream_Valid  out  1  Stream_Data holds a byte.
REQ-012 Stream_Ready  in  1  consumer accepts the byte.
REQ-013 Stream_Busy  out  1  frame in progress.
REQ-014 Stream_Done  out  1  one-cycle pulse, frame complete.
REQ-015 Stream_Abort  out  1  one-cycle pulse, frame aborted.

Function
REQ-016 Writing_Finish_Flag SHALL pass a 2-flop synchronizer (s1, s2) plus a history flop s3; start = s2 & ~s3.
REQ-017 FSM states SHALL be IDLE, HEADER, FETCH, WAIT, SEND, CSUM, DONE.
REQ-018 IDLE -> HEADER on start; Stream_Valid rises after edge n+2 when edge n first samples the flag high.
REQ-019 HEADER: Stream_Data = HEADER_BYTE, Stream_Valid = 1; on transfer go to FETCH with Read_Address = 0.
REQ-020 Transfer SHALL occur on an edge where Stream_Valid and Stream_Ready are both 1.
REQ-021 While Stream_Valid = 1 and Stream_Ready = 0, Stream_Data SHALL hold stable and Stream_Valid SHALL stay 1, except on abort.
REQ-022 FETCH/WAIT: hold Read_Address RD_LATENCY cycles, then latch all six inputs into a 48-bit holding register in one cycle and enter SEND.
REQ-023 SEND: emit bytes in order VA, VB, VC, IA, IB, IC, one per transfer; zero-bubble, next byte valid the cycle after each transfer.
REQ-024 After IC transfers: if Read_Address = NUM_SAMPLES-1 go to CSUM, else increment Read_Address and go to FETCH.
REQ-025 Checksum SHALL be an 8-bit sum mod 256 of all 6*NUM_SAMPLES data bytes, HEADER_BYTE excluded, accumulated on each transfer.
REQ-026 CSUM: Stream_Data = checksum, Stream_Valid = 1; on transfer pulse Stream_Done and go to DONE.
REQ-027 A frame SHALL be exactly 6*NUM_SAMPLES+2 bytes (24578 at default).
REQ-028 DONE SHALL wait for synchronized flag s2 = 0, then go to IDLE; the flag staying high SHALL NOT restart the frame.
REQ-029 Stream_Busy SHALL be 1 in HEADER, FETCH, WAIT, SEND and CSUM; otherwise 0.
REQ-030 Abort: s2 = 0 in any busy state -> next edge IDLE, Stream_Valid = 0, Read_Address = 0, checksum = 0, Stream_Abort pulsed 1 cycle.
REQ-031 Abort SHALL take priority over a simultaneous transfer; that byte counts as not delivered.
REQ-032 Read_Address SHALL never exceed NUM_SAMPLES-1 and SHALL NOT wrap within a frame.

Reset
REQ-033 On reset: state IDLE; s1, s2, s3 = 0; Read_Address = 0; Stream_Data = 0; Stream_Valid, Stream_Busy, Stream_Done, Stream_Abort = 0; checksum = 0.
REQ-034 Reset mid-frame SHALL drop the frame silently, with no Stream_Done and no Stream_Abort.
REQ-035 If the flag is already high when reset releases, the 0->1 sync transition SHALL start a frame.

Verification
REQ-036 Stimulus: flag rises, Stream_Ready = 1, RAM model q = addr[7:0] on all channels -> header A5, bytes in order, 24578 bytes, checksum = (6*sum(k mod 256, k = 0..4095)) mod 256 = 0x00, Stream_Done = 1 once.
REQ-037 Stimulus: Stream_Ready toggles randomly -> Stream_Data stable while stalled, no byte lost or duplicated, identical byte sequence.
REQ-038 Stimulus: flag drops at sample 100, byte 3 -> Stream_Abort pulse, Stream_Valid = 0 next cycle, Read_Address = 0, no Stream_Done.
REQ-039 Stimulus: flag held high after Stream_Done for 10000 cycles -> no second header; flag low then high -> new frame.
REQ-040 Stimulus: reset asserted at sample 2000 -> all outputs 0 next edge, no Done/Abort pulse; flag still high -> new frame after release.
REQ-041 Stimulus: flag rises at edge n -> Stream_Valid = 1 with Stream_Data = A5 after edge n+2; first Read_Address hold lasts exactly RD_LATENCY cycles.

Source files
------------

// File: rtl/sample_stream_reader_if.sv
// Byte-stream and sample-RAM read bundle between the sample stream reader
// (master) and its RAMs plus downstream byte consumer (slave).
interface sample_stream_reader_if;
  logic [11:0] Read_Address;
  logic [7:0]  PhaseA_Voltage_In;
  logic [7:0]  PhaseB_Voltage_In;
  logic [7:0]  PhaseC_Voltage_In;
  logic [7:0]  PhaseA_Current_In;
  logic [7:0]  PhaseB_Current_In;
  logic [7:0]  PhaseC_Current_In;
  logic [7:0]  Stream_Data;
  logic        Stream_Valid;
  logic        Stream_Ready;
  logic        Stream_Busy;
  logic        Stream_Done;
  logic        Stream_Abort;

  modport master (
    output Read_Address,
    input  PhaseA_Voltage_In, PhaseB_Voltage_In, PhaseC_Voltage_In,
    input  PhaseA_Current_In, PhaseB_Current_In, PhaseC_Current_In,
    output Stream_Data, Stream_Valid,
    input  Stream_Ready,
    output Stream_Busy, Stream_Done, Stream_Abort
  );

  modport slave (
    input  Read_Address,
    output PhaseA_Voltage_In, PhaseB_Voltage_In, PhaseC_Voltage_In,
    output PhaseA_Current_In, PhaseB_Current_In, PhaseC_Current_In,
    input  Stream_Data, Stream_Valid,
    output Stream_Ready,
    input  Stream_Busy, Stream_Done, Stream_Abort
  );
endinterface

// File: rtl/sample_stream_reader.sv
// Streams captured load samples as a frame: header byte, six bytes per sample
// index (VA VB VC IA IB IC), then an 8-bit additive checksum of the data bytes.
//
// state  | meaning
// IDLE   | waiting for a rising capture-complete flag
// HEADER | presenting the header byte
// FETCH  | new Read_Address presented to the RAMs
// WAIT   | RAM read pipeline settling; six q bytes latched on exit
// SEND   | emitting the six latched bytes
// CSUM   | presenting the checksum byte
// DONE   | frame complete, waiting for the flag to drop
module sample_stream_reader #(
  parameter int         NUM_SAMPLES = 4096,
  parameter int         RD_LATENCY  = 2,
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Writing_Finish_Flag,
  sample_stream_reader_if.master bus
);
  localparam int              AW        = 12;
  localparam int              LW        = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [AW-1:0]   LAST_ADDR = AW'(NUM_SAMPLES - 1);
  localparam logic [LW-1:0]   LAT_LOAD  = LW'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_FETCH, S_WAIT, S_SEND, S_CSUM, S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_s1, r_s2, r_s3;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_lat_cnt;
  logic [47:0]   r_hold;
  logic [2:0]    r_byte_idx;
  logic [7:0]    r_csum;
  logic          r_done, r_abort;

  logic          w_start, w_busy, w_valid, w_xfer, w_abort, w_last_byte;
  logic [7:0]    w_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s1    <= Writing_Finish_Flag;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
    end
  end

  always_comb begin
    w_start     = r_s2 & ~r_s3;
    w_busy      = r_state inside {S_HEADER, S_FETCH, S_WAIT, S_SEND, S_CSUM};
    w_valid     = r_state inside {S_HEADER, S_SEND, S_CSUM};
    w_xfer      = w_valid & bus.Stream_Ready;
    w_abort     = w_busy & ~r_s2;
    w_last_byte = (r_byte_idx == 3'd5);
    w_data      = 8'h00;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_nxt = S_HEADER;
      S_HEADER: begin
        w_data = HEADER_BYTE;
        if (w_xfer) w_state_nxt = S_FETCH;
      end
      S_FETCH:  w_state_nxt = S_WAIT;
      S_WAIT:   if (r_lat_cnt == '0) w_state_nxt = S_SEND;
      S_SEND: begin
        w_data = r_hold[47:40];
        if (w_xfer && w_last_byte)
          w_state_nxt = (r_addr == LAST_ADDR) ? S_CSUM : S_FETCH;
      end
      S_CSUM: begin
        w_data = r_csum;
        if (w_xfer) w_state_nxt = S_DONE;
      end
      S_DONE:   if (!r_s2) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    // A dropped flag wins over any transfer on the same edge.
    if (w_abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_lat_cnt  <= '0;
      r_hold     <= '0;
      r_byte_idx <= '0;
      r_csum     <= '0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      if (w_abort) begin
        r_abort    <= 1'b1;
        r_addr     <= '0;
        r_csum     <= '0;
        r_byte_idx <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (w_start) begin
            r_addr <= '0;
            r_csum <= '0;
          end
          S_FETCH: r_lat_cnt <= LAT_LOAD;
          S_WAIT: begin
            if (r_lat_cnt != '0) begin
              r_lat_cnt <= r_lat_cnt - 1'b1;
            end else begin
              r_hold     <= {bus.PhaseA_Voltage_In, bus.PhaseB_Voltage_In,
                             bus.PhaseC_Voltage_In, bus.PhaseA_Current_In,
                             bus.PhaseB_Current_In, bus.PhaseC_Current_In};
              r_byte_idx <= '0;
            end
          end
          S_SEND: if (w_xfer) begin
            r_csum <= r_csum + r_hold[47:40];
            r_hold <= {r_hold[39:0], 8'h00};
            if (w_last_byte) begin
              r_byte_idx <= '0;
              if (r_addr != LAST_ADDR) r_addr <= r_addr + 1'b1;
            end else begin
              r_byte_idx <= r_byte_idx + 3'd1;
            end
          end
          S_CSUM: if (w_xfer) begin
            r_done <= 1'b1;
            r_addr <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.Read_Address = r_addr;
  assign bus.Stream_Data  = w_data;
  assign bus.Stream_Valid = w_valid;
  assign bus.Stream_Busy  = w_busy;
  assign bus.Stream_Done  = r_done;
  assign bus.Stream_Abort = r_abort;
endmodule

// File: tb/tb_sample_stream_reader.sv
// Directed bench for sample_stream_reader: full default frame, stalls, abort,
// flag hold-off, mid-frame reset, and a short frame on a 4-sample instance.
module tb_sample_stream_reader;
  logic clk = 1'b0;
  logic reset, flag, flag_s, ready, sel;
  int   ram_mode;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  sample_stream_reader_if mif();
  sample_stream_reader_if sif();

  assign mif.Stream_Ready = ready;
  assign sif.Stream_Ready = ready;

  sample_stream_reader dut (
    .clk(clk), .reset(reset), .Writing_Finish_Flag(flag), .bus(mif)
  );

  sample_stream_reader #(.NUM_SAMPLES(4)) dut_s (
    .clk(clk), .reset(reset), .Writing_Finish_Flag(flag_s), .bus(sif)
  );

  function automatic logic [7:0] fq(input int mode, input int c, input int a);
    if (mode == 0) return 8'(a);
    return 8'(a * 3 + c * 41 + 1);
  endfunction

  // RAM models: q valid two edges after the address changes
  logic [11:0] m_a1, s_a1;
  always @(posedge clk) begin
    m_a1 <= mif.Read_Address;
    mif.PhaseA_Voltage_In <= fq(ram_mode, 0, int'(m_a1));
    mif.PhaseB_Voltage_In <= fq(ram_mode, 1, int'(m_a1));
    mif.PhaseC_Voltage_In <= fq(ram_mode, 2, int'(m_a1));
    mif.PhaseA_Current_In <= fq(ram_mode, 3, int'(m_a1));
    mif.PhaseB_Current_In <= fq(ram_mode, 4, int'(m_a1));
    mif.PhaseC_Current_In <= fq(ram_mode, 5, int'(m_a1));
    s_a1 <= sif.Read_Address;
    sif.PhaseA_Voltage_In <= fq(1, 0, int'(s_a1));
    sif.PhaseB_Voltage_In <= fq(1, 1, int'(s_a1));
    sif.PhaseC_Voltage_In <= fq(1, 2, int'(s_a1));
    sif.PhaseA_Current_In <= fq(1, 3, int'(s_a1));
    sif.PhaseB_Current_In <= fq(1, 4, int'(s_a1));
    sif.PhaseC_Current_In <= fq(1, 5, int'(s_a1));
  end

  logic        obs_valid, obs_busy, obs_done, obs_abort;
  logic [7:0]  obs_data;
  logic [11:0] obs_addr;
  assign obs_valid = sel ? sif.Stream_Valid : mif.Stream_Valid;
  assign obs_busy  = sel ? sif.Stream_Busy  : mif.Stream_Busy;
  assign obs_done  = sel ? sif.Stream_Done  : mif.Stream_Done;
  assign obs_abort = sel ? sif.Stream_Abort : mif.Stream_Abort;
  assign obs_data  = sel ? sif.Stream_Data  : mif.Stream_Data;
  assign obs_addr  = sel ? sif.Read_Address : mif.Read_Address;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Consumes bytes from the selected instance and checks them against the model.
  // Stops after the whole frame (plus 3 cycles) or when stop_b bytes were taken.
  task automatic stream(input int mode, input int nsamp, input bit rnd, input int stop_b,
                        output int nbytes, output int bad, output int first_bad,
                        output int dones, output int gap, output logic [7:0] csum_seen);
    int total, cyc, post, k, c;
    logic [7:0]  e_byte, acc, prev_data;
    logic [11:0] prev_addr;
    logic prev_stall, gap_open, prev_mid, err;
    total = 6 * nsamp + 2;
    nbytes = 0; bad = 0; first_bad = -1; dones = 0; gap = 0; csum_seen = 8'h00;
    acc = 8'h00; prev_data = 8'h00; prev_addr = 12'd0;
    prev_stall = 1'b0; gap_open = 1'b0; prev_mid = 1'b0;
    cyc = 0; post = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc > 80000) begin
        bad++; first_bad = -2;
        break;
      end
      if (obs_done) dones++;
      if (nbytes == total) begin
        post++;
        if (post >= 3) break;
        continue;
      end
      if (nbytes == stop_b) break;
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      err = 1'b0;
      if (obs_abort) err = 1'b1;
      if (prev_stall && (!obs_valid || obs_data !== prev_data)) err = 1'b1;
      if (prev_mid && !obs_valid) err = 1'b1;
      if (obs_busy && obs_addr !== prev_addr && obs_addr !== prev_addr + 12'd1) err = 1'b1;
      if (gap_open) begin
        if (obs_valid) gap_open = 1'b0;
        else gap++;
      end
      prev_mid = 1'b0;
      if (obs_valid && ready) begin
        if (nbytes == 0) begin
          e_byte = 8'hA5;
          gap_open = 1'b1;
        end else if (nbytes == total - 1) begin
          e_byte = acc;
          csum_seen = obs_data;
        end else begin
          k = (nbytes - 1) / 6;
          c = (nbytes - 1) % 6;
          e_byte = fq(mode, c, k);
          acc = acc + e_byte;
          prev_mid = (c < 5);
          if (obs_addr !== 12'(k)) err = 1'b1;
        end
        if (obs_data !== e_byte) err = 1'b1;
        nbytes++;
      end
      if (err) begin
        bad++;
        if (first_bad < 0) first_bad = nbytes;
      end
      prev_stall = obs_valid && !ready;
      prev_data  = obs_data;
      prev_addr  = obs_addr;
    end
  endtask

  initial begin
    int nb, bad, fb, dn, gap, n, m;
    logic [7:0] cs;
    reset = 1'b1; flag = 1'b0; flag_s = 1'b0; ready = 1'b0; sel = 1'b0; ram_mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(obs_valid), 0);
    chk("rst_data",  32'(obs_data),  0);
    chk("rst_busy",  32'(obs_busy),  0);
    chk("rst_done",  32'(obs_done),  0);
    chk("rst_abort", 32'(obs_abort), 0);
    chk("rst_addr",  32'(obs_addr),  0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // flag sampled high at edge n; header valid after edge n+2
    flag = 1'b1;
    @(negedge clk); chk("lat_n",  32'(obs_valid), 0);
    @(negedge clk); chk("lat_n1", 32'(obs_valid), 0);
    @(negedge clk);
    chk("lat_n2_valid", 32'(obs_valid), 1);
    chk("lat_n2_data",  32'(obs_data),  32'hA5);
    chk("lat_n2_busy",  32'(obs_busy),  1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hdr_stall", 32'({obs_valid, obs_data}), 32'h1A5);
    end

    stream(0, 4096, 1'b0, -1, nb, bad, fb, dn, gap, cs);
    if (bad != 0) $display("[TB] frame0 first bad byte index %0d", fb);
    chk("f0_bad",  32'(bad), 0);
    chk("f0_len",  32'(nb),  24578);
    chk("f0_csum", 32'(cs),  32'h00);
    chk("f0_done", 32'(dn),  1);
    chk("f0_gap",  32'(gap), 3);
    chk("f0_post_busy", 32'(obs_busy), 0);

    n = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (obs_valid || obs_busy) n++;
    end
    chk("hold_no_restart", 32'(n), 0);

    flag = 1'b0;
    repeat (5) @(negedge clk);
    ram_mode = 1;
    flag = 1'b1;
    stream(1, 4096, 1'b1, 1 + 6 * 100 + 3, nb, bad, fb, dn, gap, cs);
    if (bad != 0) $display("[TB] frame1 first bad byte index %0d", fb);
    chk("f1_stall_bad", 32'(bad), 0);
    chk("f1_no_done",   32'(dn),  0);
    chk("f1_gap",       32'(gap), 3);

    ready = 1'b1;
    flag = 1'b0;
    n = 0; dn = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (obs_done) dn++;
      if (obs_abort) begin
        n = i;
        break;
      end
    end
    chk("abort_delay", 32'(n),         3);
    chk("abort_valid", 32'(obs_valid), 0);
    chk("abort_addr",  32'(obs_addr),  0);
    chk("abort_busy",  32'(obs_busy),  0);
    @(negedge clk);
    if (obs_done) dn++;
    chk("abort_one_cycle", 32'(obs_abort), 0);
    chk("abort_no_done",   32'(dn),        0);

    repeat (3) @(negedge clk);
    flag = 1'b1;
    stream(1, 4096, 1'b0, 1 + 6 * 2000, nb, bad, fb, dn, gap, cs);
    chk("f2_bad", 32'(bad), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_valid", 32'(obs_valid), 0);
    chk("rstmid_busy",  32'(obs_busy),  0);
    chk("rstmid_addr",  32'(obs_addr),  0);
    chk("rstmid_data",  32'(obs_data),  0);
    n = 0;
    if (obs_done || obs_abort) n++;
    repeat (2) begin
      @(negedge clk);
      if (obs_done || obs_abort) n++;
    end
    reset = 1'b0;
    m = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (obs_done || obs_abort) n++;
      if (obs_valid) begin
        m = i;
        break;
      end
    end
    chk("rstmid_no_pulse", 32'(n),        0);
    chk("restart_delay",   32'(m),        3);
    chk("restart_header",  32'(obs_data), 32'hA5);

    flag = 1'b0;
    repeat (4) @(negedge clk);
    sel = 1'b1;
    flag_s = 1'b1;
    stream(1, 4, 1'b0, -1, nb, bad, fb, dn, gap, cs);
    if (bad != 0) $display("[TB] small frame first bad byte index %0d", fb);
    chk("s_bad",  32'(bad), 0);
    chk("s_len",  32'(nb),  26);
    chk("s_csum", 32'(cs),  32'h20);
    chk("s_done", 32'(dn),  1);
    chk("s_gap",  32'(gap), 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
